// File: rtl/data_mem_arbiter_pkg.sv
// Shared memory-subsystem definitions: arbiter FSM encoding and requester IDs.
package data_mem_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_e;

    // Requester identifiers; also the bit index of each requester in grant vectors
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LD  = 1'b1;

    // Read-latency counter: wide enough for the legal range 1..3
    localparam int unsigned LAT_CNT_W = 2;
    typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. A single requester always wins; on contention the
// favoured requester wins and the favour passes to the other one.
module rr_arb2
    import data_mem_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    // Index of the requester that wins the next contention
    logic prio_q;
    logic prio_d;

    // Grant decode and priority update; only a contended grant moves the pointer
    always_comb begin
        gnt_o  = '0;
        prio_d = prio_q;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11: begin
                    gnt_o  = (prio_q == REQ_LD) ? 2'b10 : 2'b01;
                    prio_d = ~prio_q;
                end
                default: gnt_o = '0;
            endcase
        end
    end

    // Priority flop, favouring the CPU after reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= REQ_CPU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Data-memory arbiter: shares one BRAM port between the CPU (r0) and the
// loader/DMA (r1). Writes retire in the grant cycle; reads block further
// grants until the BRAM data has been captured into rdata.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned AW     = 12,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r1_req,
    input  logic          r0_we,
    input  logic          r1_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r0_wdata,
    input  logic [DW-1:0] r1_wdata,
    output logic          r0_gnt,
    output logic          r1_gnt,
    output logic          r0_rvalid,
    output logic          r1_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
        $error("data_mem_arbiter: RD_LAT must be in 1..3");
    end

    arb_state_e    state_q;
    lat_cnt_t      cnt_q;
    logic          owner_q;
    logic [DW-1:0] rdata_q;
    logic          r0_rvalid_q;
    logic          r1_rvalid_q;

    logic [1:0]    req_vec;
    logic [1:0]    gnt_vec;
    logic          arb_en;

    assign req_vec = {r1_req, r0_req};
    // Grants only from IDLE, and never while reset is asserted
    assign arb_en  = (state_q == IDLE) && !rst;

    rr_arb2 u_rr_arb2 (
        .clk_i (clk),
        .rst_i (rst),
        .req_i (req_vec),
        .en_i  (arb_en),
        .gnt_o (gnt_vec)
    );

    assign r0_gnt    = gnt_vec[REQ_CPU];
    assign r1_gnt    = gnt_vec[REQ_LD];
    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign rdata     = rdata_q;

    // BRAM port mux: drive the granted requester's command, idle otherwise
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_vec[REQ_LD]) begin
            mem_en    = 1'b1;
            mem_we    = r1_we;
            mem_addr  = r1_addr;
            mem_wdata = r1_wdata;
        end else if (gnt_vec[REQ_CPU]) begin
            mem_en    = 1'b1;
            mem_we    = r0_we;
            mem_addr  = r0_addr;
            mem_wdata = r0_wdata;
        end
    end

    // Read-sequencing FSM: launch on a read grant, count down the BRAM latency,
    // capture data and pulse the owner's rvalid on the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= REQ_CPU;
            rdata_q     <= '0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
        end else begin
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_en && !mem_we) begin
                        cnt_q   <= lat_cnt_t'(RD_LAT);
                        owner_q <= gnt_vec[REQ_LD] ? REQ_LD : REQ_CPU;
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    cnt_q <= cnt_q - lat_cnt_t'(1);
                    // Counter hits zero at this edge: BRAM data is valid now
                    if (cnt_q <= lat_cnt_t'(1)) begin
                        cnt_q       <= '0;
                        rdata_q     <= mem_rdata;
                        r0_rvalid_q <= (owner_q == REQ_CPU);
                        r1_rvalid_q <= (owner_q == REQ_LD);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with BRAM models at
// read latencies 1 (dut) and 2 (dut2).
module tb_data_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // ---------------- RD_LAT = 1 instance ----------------
    logic          r0_req, r1_req, r0_we, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    data_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
        .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    logic [DW-1:0] rd_a;
    assign mem_rdata = rd_a;

    // Latency-1 BRAM; preload happens under reset
    always @(posedge clk) begin
        if (rst) begin
            mem_a[12'h010] <= 32'hDEADBEEF;
            rd_a           <= '0;
        end else if (mem_en) begin
            if (mem_we) mem_a[mem_addr] <= mem_wdata;
            else        rd_a <= mem_a[mem_addr];
        end
    end

    // ---------------- RD_LAT = 2 instance ----------------
    logic          b_r0_req, b_r1_req, b_r0_we, b_r1_we;
    logic [AW-1:0] b_r0_addr, b_r1_addr;
    logic [DW-1:0] b_r0_wdata, b_r1_wdata;
    logic          b_r0_gnt, b_r1_gnt, b_r0_rvalid, b_r1_rvalid;
    logic [DW-1:0] b_rdata;
    logic          b_mem_en, b_mem_we;
    logic [AW-1:0] b_mem_addr;
    logic [DW-1:0] b_mem_wdata, b_mem_rdata;

    data_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .r0_req(b_r0_req), .r1_req(b_r1_req), .r0_we(b_r0_we), .r1_we(b_r1_we),
        .r0_addr(b_r0_addr), .r1_addr(b_r1_addr), .r0_wdata(b_r0_wdata), .r1_wdata(b_r1_wdata),
        .r0_gnt(b_r0_gnt), .r1_gnt(b_r1_gnt), .r0_rvalid(b_r0_rvalid), .r1_rvalid(b_r1_rvalid),
        .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    logic [DW-1:0] mem_b [0:(1<<AW)-1];
    logic [DW-1:0] rd_b1, rd_b2;
    assign b_mem_rdata = rd_b2;

    // Latency-2 BRAM
    always @(posedge clk) begin
        if (rst) begin
            mem_b[12'h020] <= 32'hCAFEF00D;
            rd_b1          <= '0;
            rd_b2          <= '0;
        end else begin
            if (b_mem_en) begin
                if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
                else          rd_b1 <= mem_b[b_mem_addr];
            end
            rd_b2 <= rd_b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0;
        r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
        b_r0_req = 0; b_r1_req = 0; b_r0_we = 0; b_r1_we = 0;
        b_r0_addr = '0; b_r1_addr = '0; b_r0_wdata = '0; b_r1_wdata = '0;

        // Reset, with a request pending that reset must override
        r0_req = 1;
        @(negedge clk);
        check("rst_gnt0", r0_gnt, 0);
        check("rst_en", mem_en, 0);
        step();
        @(negedge clk);
        check("rst_rdata", rdata, 0);
        check("rst_rvalid", r0_rvalid, 0);
        check("rst_we", mem_we, 0);
        check("rst_b_rdata", b_rdata, 0);
        step();
        rst = 0; r0_req = 0;

        // Single read, RD_LAT=1
        r0_req = 1; r0_we = 0; r0_addr = 12'h010;
        @(negedge clk);
        check("t1_gnt0", r0_gnt, 1);
        check("t1_gnt1", r1_gnt, 0);
        check("t1_en", mem_en, 1);
        check("t1_we", mem_we, 0);
        check("t1_addr", mem_addr, 12'h010);
        step(); r0_req = 0;
        @(negedge clk);
        check("t1_wait_en", mem_en, 0);
        check("t1_rv_early", r0_rvalid, 0);
        step();
        @(negedge clk);
        check("t1_rvalid", r0_rvalid, 1);
        check("t1_rdata", rdata, 32'hDEADBEEF);
        step();
        @(negedge clk);
        check("t1_rv_pulse", r0_rvalid, 0);
        check("t1_rdata_hold", rdata, 32'hDEADBEEF);
        step();

        // Contention on writes: alternate r0,r1,r0,r1
        r0_req = 1; r1_req = 1; r0_we = 1; r1_we = 1;
        r0_addr = 12'h100; r0_wdata = 32'hA0A00000;
        r1_addr = 12'h200; r1_wdata = 32'hB0B00000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_gnt0", r0_gnt, (i % 2 == 0));
            check("t2_gnt1", r1_gnt, (i % 2 != 0));
            check("t2_we", mem_we, 1);
            check("t2_addr", mem_addr, (i % 2 == 0) ? 12'h100 : 12'h200);
            step();
        end
        r0_req = 0; r1_req = 0;

        // Read blocking: r1 reads, r0 waits through RD_WAIT
        r1_req = 1; r1_we = 0; r1_addr = 12'h100;
        @(negedge clk);
        check("t3_gnt1", r1_gnt, 1);
        step(); r1_req = 0;
        r0_req = 1; r0_we = 0; r0_addr = 12'h010;
        @(negedge clk);
        check("t3_blocked", r0_gnt, 0);
        check("t3_wait_en", mem_en, 0);
        step();
        @(negedge clk);
        check("t3_rvalid1", r1_rvalid, 1);
        check("t3_rdata1", rdata, 32'hA0A00000);
        check("t3_gnt0", r0_gnt, 1);
        step(); r0_req = 0;
        @(negedge clk);
        check("t3_rv0_early", r0_rvalid, 0);
        step();
        @(negedge clk);
        check("t3_rvalid0", r0_rvalid, 1);
        check("t3_rdata0", rdata, 32'hDEADBEEF);
        step();

        // Write then read at the top address
        r1_req = 1; r1_we = 1; r1_addr = 12'hFFF; r1_wdata = 32'h12345678;
        @(negedge clk);
        check("t4_wgnt", r1_gnt, 1);
        check("t4_we", mem_we, 1);
        check("t4_addr", mem_addr, 12'hFFF);
        step(); r1_req = 0;
        r0_req = 1; r0_we = 0; r0_addr = 12'hFFF;
        @(negedge clk);
        check("t4_rgnt", r0_gnt, 1);
        step(); r0_req = 0;
        step();
        @(negedge clk);
        check("t4_rvalid", r0_rvalid, 1);
        check("t4_rdata", rdata, 32'h12345678);
        step();

        // Reset mid-read: move pointer to r1 first, then abort an r1 read
        r0_req = 1; r1_req = 1; r0_we = 1; r1_we = 1;
        r0_addr = 12'h300; r1_addr = 12'h301;
        @(negedge clk);
        check("t5_pre_gnt0", r0_gnt, 1);
        step(); r0_req = 0; r1_we = 0;
        @(negedge clk);
        check("t5_rgnt1", r1_gnt, 1);
        step(); r1_req = 0; rst = 1;
        @(negedge clk);
        check("t5_rv_in_rst", r1_rvalid, 0);
        step(); rst = 0;
        @(negedge clk);
        check("t5_rv_aborted", r1_rvalid, 0);
        check("t5_rdata_rst", rdata, 0);
        step();
        r0_req = 1; r1_req = 1; r0_we = 1; r1_we = 1;
        @(negedge clk);
        check("t5_gnt0", r0_gnt, 1);
        check("t5_gnt1", r1_gnt, 0);
        step(); r0_req = 0; r1_req = 0;

        // RD_LAT=2: rvalid three cycles after the grant
        b_r0_req = 1; b_r0_we = 0; b_r0_addr = 12'h020;
        @(negedge clk);
        check("t6_gnt", b_r0_gnt, 1);
        step(); b_r0_req = 0;
        @(negedge clk);
        check("t6_rv_c1", b_r0_rvalid, 0);
        step();
        @(negedge clk);
        check("t6_rv_c2", b_r0_rvalid, 0);
        step();
        @(negedge clk);
        check("t6_rv_c3", b_r0_rvalid, 1);
        check("t6_rdata", b_rdata, 32'hCAFEF00D);
        step();
        @(negedge clk);
        check("t6_rv_c4", b_r0_rvalid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
